// File: rtl/load_store_unit.sv
// load_store_unit
//   Memory-access stage behind the ALU. Accepts one request (alucode, effective
//   address, rs2 store data), runs at most one valid/ack data-memory transaction
//   and returns sign/zero-extended load data for writeback. One request in flight.
//
// Optional feature macro: LSU_MISALIGN_CHECK_EN
//   defined   : misaligned LH/LHU/SH/LW/SW skip the bus and respond with
//               resp_err=1, resp_misalign=1
//   undefined : addresses are truncated to natural alignment, resp_misalign=0
//
// Parameters
//   MAX_WAIT   cycles mem_req may stay unacknowledged before timeout (1..255)
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/req_ready       request handshake (ready only in IDLE)
//   alucode, addr, store_data request payload
//   resp_valid/resp_ready     response handshake
//   load_data                 extended load result (0 for stores/non-mem/error)
//   resp_err, resp_misalign   error flags
//   mem_req/mem_ack           bus handshake
//   mem_we, mem_addr, mem_be, mem_wdata, mem_rdata   bus payload
//
// State | meaning
//   IDLE | waiting for a request, req_ready=1
//   BUS  | mem_req asserted, waiting for mem_ack or timeout
//   RESP | resp_valid asserted, holding result until resp_ready

module load_store_unit #(
   parameter int unsigned MAX_WAIT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [5:0]  alucode,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] load_data,
   output logic        resp_err,
   output logic        resp_misalign,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   // Memory op codes, mirrored from the ALU_* definitions in define.vh.
   localparam logic [5:0] ALU_LB  = 6'd22;
   localparam logic [5:0] ALU_LH  = 6'd23;
   localparam logic [5:0] ALU_LW  = 6'd24;
   localparam logic [5:0] ALU_LBU = 6'd25;
   localparam logic [5:0] ALU_LHU = 6'd26;
   localparam logic [5:0] ALU_SB  = 6'd27;
   localparam logic [5:0] ALU_SH  = 6'd28;
   localparam logic [5:0] ALU_SW  = 6'd29;

   localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

   typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

   state_t      state, state_nx;
   logic [5:0]  op_q;
   logic [31:0] addr_q;
   logic [31:0] sd_q;
   logic [7:0]  wait_cnt;
   logic [31:0] res_q;
   logic        err_q;
   logic        mis_q;

   logic        accept;
   logic        in_is_mem;
   logic        in_misalign;
   logic        timeout;

   function automatic logic is_store(input logic [5:0] op);
      return (op == ALU_SB) || (op == ALU_SH) || (op == ALU_SW);
   endfunction

   function automatic logic is_load(input logic [5:0] op);
      return (op == ALU_LB) || (op == ALU_LH) || (op == ALU_LW) ||
             (op == ALU_LBU) || (op == ALU_LHU);
   endfunction

   function automatic logic [31:0] load_ext(input logic [5:0]  op,
                                            input logic [1:0]  a,
                                            input logic [31:0] rd);
      logic [7:0]  b;
      logic [15:0] h;
      b = 8'(rd >> {a, 3'b000});
      h = 16'(rd >> {a[1], 4'b0000});
      case (op)
         ALU_LB:  return {{24{b[7]}}, b};
         ALU_LBU: return {24'h0, b};
         ALU_LH:  return {{16{h[15]}}, h};
         ALU_LHU: return {16'h0, h};
         ALU_LW:  return rd;
         default: return 32'h0;
      endcase
   endfunction

   assign accept    = (state == S_IDLE) && req_valid;
   assign in_is_mem = is_load(alucode) || is_store(alucode);
   assign timeout   = (state == S_BUS) && !mem_ack && (wait_cnt == WAIT_LAST);

`ifdef LSU_MISALIGN_CHECK_EN
   always_comb begin
      in_misalign = 1'b0;
      case (alucode)
         ALU_LH, ALU_LHU, ALU_SH: in_misalign = addr[0];
         ALU_LW, ALU_SW:          in_misalign = (addr[1:0] != 2'b00);
         default:                 in_misalign = 1'b0;
      endcase
   end
`else
   assign in_misalign = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         op_q     <= '0;
         addr_q   <= '0;
         sd_q     <= '0;
         wait_cnt <= '0;
         res_q    <= '0;
         err_q    <= 1'b0;
         mis_q    <= 1'b0;
      end else begin
         state <= state_nx;
         if (accept) begin
            op_q     <= alucode;
            addr_q   <= addr;
            sd_q     <= store_data;
            wait_cnt <= '0;
            res_q    <= '0;
            err_q    <= in_misalign;
            mis_q    <= in_misalign;
         end else if (state == S_BUS) begin
            if (mem_ack) begin
               res_q <= load_ext(op_q, addr_q[1:0], mem_rdata);
               err_q <= 1'b0;
            end else if (timeout) begin
               res_q <= '0;
               err_q <= 1'b1;
            end else begin
               wait_cnt <= wait_cnt + 8'd1;
            end
         end
      end
   end

   always_comb begin
      state_nx      = state;
      req_ready     = 1'b0;
      resp_valid    = 1'b0;
      load_data     = '0;
      resp_err      = 1'b0;
      resp_misalign = 1'b0;
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      mem_addr      = '0;
      mem_be        = '0;
      mem_wdata     = '0;
      case (state)
         S_IDLE: begin
            req_ready = 1'b1;
            if (accept)
               state_nx = (in_is_mem && !in_misalign) ? S_BUS : S_RESP;
         end
         S_BUS: begin
            mem_req  = 1'b1;
            mem_we   = is_store(op_q);
            mem_addr = {addr_q[31:2], 2'b00};
            case (op_q)
               ALU_SB: begin
                  mem_be    = 4'b0001 << addr_q[1:0];
                  mem_wdata = {4{sd_q[7:0]}};
               end
               ALU_SH: begin
                  mem_be    = 4'b0011 << {addr_q[1], 1'b0};
                  mem_wdata = {2{sd_q[15:0]}};
               end
               ALU_SW: begin
                  mem_be    = 4'hF;
                  mem_wdata = sd_q;
               end
               default: mem_be = 4'hF;
            endcase
            if (mem_ack || timeout)
               state_nx = S_RESP;
         end
         S_RESP: begin
            resp_valid    = 1'b1;
            load_data     = res_q;
            resp_err      = err_q;
            resp_misalign = mis_q;
            if (resp_ready)
               state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit built with MAX_WAIT=4. Inputs change and
// outputs are sampled on the falling clock edge.

module tb_load_store_unit;

   localparam logic [5:0] ALU_ADD = 6'd1;
   localparam logic [5:0] ALU_LB  = 6'd22;
   localparam logic [5:0] ALU_LH  = 6'd23;
   localparam logic [5:0] ALU_LW  = 6'd24;
   localparam logic [5:0] ALU_LBU = 6'd25;
   localparam logic [5:0] ALU_LHU = 6'd26;
   localparam logic [5:0] ALU_SB  = 6'd27;
   localparam logic [5:0] ALU_SH  = 6'd28;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [5:0]  alucode;
   logic [31:0] addr;
   logic [31:0] store_data;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] load_data;
   logic        resp_err;
   logic        resp_misalign;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   load_store_unit #(.MAX_WAIT(4)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .alucode(alucode), .addr(addr), .store_data(store_data),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .load_data(load_data), .resp_err(resp_err), .resp_misalign(resp_misalign),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Present one request for a single cycle; returns at the falling edge after accept.
   task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] sd);
      req_valid  = 1'b1;
      alucode    = op;
      addr       = a;
      store_data = sd;
      step();
      req_valid  = 1'b0;
   endtask

   // Ack the pending bus cycle immediately, then check and consume the response.
   task automatic load_check(input string tag, input logic [5:0] op, input logic [31:0] a,
                             input logic [31:0] rd, input logic [31:0] exp);
      issue(op, a, 32'h0);
      chk({tag, "_mem_req"}, 32'(mem_req), 32'd1);
      mem_ack   = 1'b1;
      mem_rdata = rd;
      step();
      mem_ack = 1'b0;
      chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd1);
      chk({tag, "_load_data"}, load_data, exp);
      chk({tag, "_resp_err"}, 32'(resp_err), 32'd0);
      resp_ready = 1'b1;
      step();
      resp_ready = 1'b0;
      chk({tag, "_back_idle"}, 32'(req_ready), 32'd1);
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; alucode = '0; addr = '0; store_data = '0;
      resp_ready = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
      @(negedge clk);
      step();
      rst = 1'b0;
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_load_data", load_data, 32'h0);

      // Loads: minimum latency, all extension variants
      issue(ALU_LB, 32'h103, 32'h0);
      chk("lb_mem_addr", mem_addr, 32'h100);
      chk("lb_mem_be", 32'(mem_be), 32'hF);
      chk("lb_mem_we", 32'(mem_we), 32'd0);
      mem_ack = 1'b1; mem_rdata = 32'h80FF_1234;
      step();
      mem_ack = 1'b0;
      chk("lb_mem_req_drop", 32'(mem_req), 32'd0);
      chk("lb_load_data", load_data, 32'hFFFF_FF80);
      chk("lb_resp_err", 32'(resp_err), 32'd0);
      resp_ready = 1'b1;
      step();
      resp_ready = 1'b0;

      load_check("lbu", ALU_LBU, 32'h103, 32'h80FF_1234, 32'h0000_0080);
      load_check("lb1", ALU_LB,  32'h101, 32'h80FF_1234, 32'h0000_0012);
      load_check("lh",  ALU_LH,  32'h102, 32'h80FF_1234, 32'hFFFF_80FF);
      load_check("lhu", ALU_LHU, 32'h100, 32'h80FF_9234, 32'h0000_9234);
      load_check("lw",  ALU_LW,  32'h104, 32'h80FF_1234, 32'h80FF_1234);

      // SH with one wait cycle: bus payload must stay stable
      issue(ALU_SH, 32'h202, 32'hDEAD_BEEF);
      for (int i = 0; i < 2; i++) begin
         chk("sh_mem_req", 32'(mem_req), 32'd1);
         chk("sh_mem_addr", mem_addr, 32'h200);
         chk("sh_mem_be", 32'(mem_be), 32'b1100);
         chk("sh_mem_wdata", mem_wdata, 32'hBEEF_BEEF);
         chk("sh_mem_we", 32'(mem_we), 32'd1);
         if (i == 1) mem_ack = 1'b1;
         step();
      end
      mem_ack = 1'b0;
      chk("sh_resp_valid", 32'(resp_valid), 32'd1);
      chk("sh_load_data", load_data, 32'h0);
      resp_ready = 1'b1;
      step();
      resp_ready = 1'b0;

      issue(ALU_SB, 32'h201, 32'h1234_56EF);
      chk("sb_mem_be", 32'(mem_be), 32'b0010);
      chk("sb_mem_wdata", mem_wdata, 32'hEFEF_EFEF);
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      resp_ready = 1'b1;
      step();
      resp_ready = 1'b0;

      // Timeout: mem_req held exactly 4 cycles, then error response
      issue(ALU_LW, 32'h108, 32'h0);
      for (int i = 0; i < 4; i++) begin
         chk("to_mem_req", 32'(mem_req), 32'd1);
         chk("to_no_resp", 32'(resp_valid), 32'd0);
         step();
      end
      chk("to_mem_req_drop", 32'(mem_req), 32'd0);
      chk("to_resp_valid", 32'(resp_valid), 32'd1);
      chk("to_resp_err", 32'(resp_err), 32'd1);
      chk("to_load_data", load_data, 32'h0);

      // Held response with stray ack and a request waiting
      mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
      req_valid = 1'b1; alucode = ALU_ADD; addr = 32'h0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("hold_resp_valid", 32'(resp_valid), 32'd1);
         chk("hold_resp_err", 32'(resp_err), 32'd1);
         chk("hold_load_data", load_data, 32'h0);
         chk("hold_req_ready", 32'(req_ready), 32'd0);
         chk("hold_mem_req", 32'(mem_req), 32'd0);
      end
      mem_ack = 1'b0;
      resp_ready = 1'b1;
      step();
      resp_ready = 1'b0;
      chk("hold_idle_ready", 32'(req_ready), 32'd1);
      chk("hold_idle_no_resp", 32'(resp_valid), 32'd0);
      step();
      req_valid = 1'b0;
      chk("add_resp_valid", 32'(resp_valid), 32'd1);
      chk("add_load_data", load_data, 32'h0);
      chk("add_resp_err", 32'(resp_err), 32'd0);
      chk("add_mem_req", 32'(mem_req), 32'd0);
      resp_ready = 1'b1;
      step();
      resp_ready = 1'b0;

      // Misaligned word load
      issue(ALU_LW, 32'h301, 32'h0);
`ifdef LSU_MISALIGN_CHECK_EN
      chk("mis_mem_req", 32'(mem_req), 32'd0);
      chk("mis_resp_valid", 32'(resp_valid), 32'd1);
      chk("mis_resp_err", 32'(resp_err), 32'd1);
      chk("mis_resp_misalign", 32'(resp_misalign), 32'd1);
      chk("mis_load_data", load_data, 32'h0);
`else
      chk("mis_mem_req", 32'(mem_req), 32'd1);
      chk("mis_mem_addr", mem_addr, 32'h300);
      mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
      step();
      mem_ack = 1'b0;
      chk("mis_load_data", load_data, 32'hCAFE_F00D);
      chk("mis_resp_misalign", 32'(resp_misalign), 32'd0);
      chk("mis_resp_err", 32'(resp_err), 32'd0);
`endif
      resp_ready = 1'b1;
      step();
      resp_ready = 1'b0;

      // Reset while in BUS
      issue(ALU_LW, 32'h400, 32'h0);
      chk("rb_mem_req", 32'(mem_req), 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rb_mem_req_drop", 32'(mem_req), 32'd0);
      chk("rb_req_ready", 32'(req_ready), 32'd1);
      chk("rb_resp_valid", 32'(resp_valid), 32'd0);
      issue(ALU_ADD, 32'h400, 32'h0);
      chk("rb_add_resp_valid", 32'(resp_valid), 32'd1);
      chk("rb_add_mem_req", 32'(mem_req), 32'd0);
      chk("rb_add_load_data", load_data, 32'h0);
      resp_ready = 1'b1;
      step();
      resp_ready = 1'b0;
      chk("rb_final_idle", 32'(req_ready), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
